// File: rtl/multi_signed_seq_if.sv
// Operand/result bundle for the sequential signed multiplier.
// The requester drives the operands and start; the multiplier returns prodt and a valid pulse.
interface multi_signed_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   mlier;
    logic [WIDTH-1:0]   mcand;
    logic               start;
    logic [2*WIDTH-1:0] prodt;
    logic               valid;

    modport master (
        output mlier,
        output mcand,
        output start,
        input  prodt,
        input  valid
    );

    modport slave (
        input  mlier,
        input  mcand,
        input  start,
        output prodt,
        output valid
    );
endinterface

// File: rtl/multi_signed_seq.sv
// Radix-2 shift-add signed multiplier working on operand magnitudes, one step per clock.
// VAR_LATENCY=1 stops as soon as the remaining multiplier bits are all zero.
module multi_signed_seq #(
    parameter int VAR_LATENCY = 0,
    parameter int WIDTH       = 32
) (
    input  logic               clock,
    input  logic               reset,
    multi_signed_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

    state_t             r_state;
    logic               r_startQ;
    logic               r_sgn;
    logic [WIDTH:0]     r_mlier;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_prodt;
    logic               r_valid;
    logic [CW-1:0]      r_count;

    logic               w_launch;
    logic [WIDTH:0]     w_mlierMag;
    logic [WIDTH:0]     w_mcandMag;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_accNext;
    logic [WIDTH:0]     w_mlierNext;
    logic               w_lastStep;
    logic [2*WIDTH-1:0] w_result;
    logic               w_zeroOperand;

    // Magnitudes carry one extra bit so the most negative operand maps to 2^(WIDTH-1).
    assign w_launch    = bus.start & ~r_startQ;
    assign w_mlierMag  = bus.mlier[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {1'b1, bus.mlier})
                                            : {1'b0, bus.mlier};
    assign w_mcandMag  = bus.mcand[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {1'b1, bus.mcand})
                                            : {1'b0, bus.mcand};
    assign w_addend    = r_mlier[0] ? r_mcand : '0;
    assign w_accNext   = r_acc + w_addend;
    assign w_mlierNext = r_mlier >> 1;
    assign w_lastStep  = (VAR_LATENCY != 0) ? (w_mlierNext == '0) : (r_count == LAST_STEP);
    assign w_zeroOperand = (VAR_LATENCY != 0) && ((bus.mlier == '0) || (bus.mcand == '0));

    // A zero magnitude product stays zero even when the sign flag is set.
    assign w_result = (r_sgn && (w_accNext != '0)) ? ('0 - w_accNext) : w_accNext;

    assign bus.prodt = r_prodt;
    assign bus.valid = r_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_startQ <= 1'b0;
            r_sgn    <= 1'b0;
            r_mlier  <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_prodt  <= '0;
            r_valid  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_startQ <= bus.start;
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (w_launch) begin
                        r_sgn   <= bus.mlier[WIDTH-1] ^ bus.mcand[WIDTH-1];
                        r_mlier <= w_mlierMag;
                        r_mcand <= {{(WIDTH-1){1'b0}}, w_mcandMag};
                        r_acc   <= '0;
                        r_count <= '0;
                        if (w_zeroOperand) begin
                            r_prodt <= '0;
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_acc   <= w_accNext;
                    r_mlier <= w_mlierNext;
                    r_mcand <= r_mcand << 1;
                    r_count <= r_count + 1'b1;
                    if (w_lastStep) begin
                        r_prodt <= w_result;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multi_signed_seq.sv
// Runs the fixed- and variable-latency builds side by side on identical operands and
// compares both against a plain signed 64-bit product computed in the bench.
module tb_multi_signed_seq;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    multi_signed_seq_if #(.WIDTH(32)) ifFix ();
    multi_signed_seq_if #(.WIDTH(32)) ifVar ();

    multi_signed_seq #(.VAR_LATENCY(0), .WIDTH(32)) dutFix (
        .clock (clock),
        .reset (reset),
        .bus   (ifFix)
    );

    multi_signed_seq #(.VAR_LATENCY(1), .WIDTH(32)) dutVar (
        .clock (clock),
        .reset (reset),
        .bus   (ifVar)
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    task automatic driveOperands(input logic [31:0] a, input logic [31:0] b);
        ifFix.mlier = a;
        ifVar.mlier = a;
        ifFix.mcand = b;
        ifVar.mcand = b;
    endtask

    task automatic setStart(input logic s);
        ifFix.start = s;
        ifVar.start = s;
    endtask

    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    // Index of the highest set bit of |a|, or -1 for zero.
    function automatic int highestBit(input logic [31:0] a);
        longint m;
        int k;
        m = longint'($signed(a));
        if (m < 0) m = -m;
        k = -1;
        while (m > 0) begin
            k++;
            m = m / 2;
        end
        return k;
    endfunction

    // One operation on both builds: launch, watch 40 edges, then check result, latency and pulse count.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int holdCycles,
                                 input bit zeroAfter, input string tag);
        logic [63:0] expected;
        logic [63:0] prodFix;
        logic [63:0] prodVar;
        int latFix;
        int latVar;
        int pulsesFix;
        int pulsesVar;
        int k;
        expected  = refProduct(a, b);
        k         = highestBit(a);
        latFix    = -1;
        latVar    = -1;
        pulsesFix = 0;
        pulsesVar = 0;
        prodFix   = '0;
        prodVar   = '0;
        @(negedge clock);
        driveOperands(a, b);
        setStart(1'b1);
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (ifFix.valid) begin
                pulsesFix++;
                if (latFix < 0) begin
                    latFix  = n + 1;
                    prodFix = ifFix.prodt;
                end
            end
            if (ifVar.valid) begin
                pulsesVar++;
                if (latVar < 0) begin
                    latVar  = n + 1;
                    prodVar = ifVar.prodt;
                end
            end
            if (n == 0 && zeroAfter) driveOperands(32'h0, 32'h0);
            if (n + 1 >= holdCycles) setStart(1'b0);
        end
        setStart(1'b0);
        checkOutput({tag, "/fix.prodt"}, prodFix, expected);
        checkOutput({tag, "/fix.hold"}, ifFix.prodt, expected);
        checkOutput({tag, "/fix.pulses"}, 64'(pulsesFix), 64'd1);
        checkOutput({tag, "/fix.latency"}, 64'(latFix), 64'd33);
        checkOutput({tag, "/var.prodt"}, prodVar, expected);
        checkOutput({tag, "/var.hold"}, ifVar.prodt, expected);
        checkOutput({tag, "/var.pulses"}, 64'(pulsesVar), 64'd1);
        if (a == 32'h0 || b == 32'h0)
            checkOutput({tag, "/var.latency"}, 64'(latVar), 64'd1);
        else
            checkOutput({tag, "/var.latencyRange"}, 64'(latVar >= k + 1 && latVar <= k + 2 && latVar <= 33), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int pulses;

        reset = 1'b1;
        driveOperands(32'h0, 32'h0);
        setStart(1'b0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset/fix.prodt", ifFix.prodt, 64'h0);
        checkOutput("reset/fix.valid", 64'(ifFix.valid), 64'd0);
        checkOutput("reset/var.prodt", ifVar.prodt, 64'h0);
        checkOutput("reset/var.valid", 64'(ifVar.valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, 1, 1'b0, "maxPos");
        applyStimulus(32'h00000001, 32'h80000000, 1, 1'b0, "oneTimesMin");
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b0, "negOneSq");
        applyStimulus(32'h80000000, 32'h80000000, 1, 1'b0, "minSq");
        applyStimulus(32'h87654321, 32'h80000000, 1, 1'b0, "mixedMin");
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1, 1'b0, "minTimesNegOne");
        applyStimulus(32'h00000000, 32'h80000000, 1, 1'b0, "zeroMlier");
        applyStimulus(32'h00000005, 32'h00000000, 1, 1'b0, "zeroMcand");
        applyStimulus(32'h12345678, 32'hFEDCBA98, 33, 1'b1, "heldStart");

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) ra = ra >> $urandom_range(0, 31);
            if (i % 3 == 2) ra = 32'($urandom_range(0, 511)) - 32'd256;
            applyStimulus(ra, rb, $urandom_range(1, 4), 1'b0, $sformatf("random%0d", i));
        end

        // Abort an operation mid-iteration; nothing may come out afterwards.
        @(negedge clock);
        driveOperands(32'h7FFFFFFF, 32'h7FFFFFFF);
        setStart(1'b1);
        repeat (10) @(negedge clock);
        setStart(1'b0);
        reset = 1'b1;
        #1;
        checkOutput("midReset/fix.prodt", ifFix.prodt, 64'h0);
        checkOutput("midReset/fix.valid", 64'(ifFix.valid), 64'd0);
        checkOutput("midReset/var.prodt", ifVar.prodt, 64'h0);
        checkOutput("midReset/var.valid", 64'(ifVar.valid), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (ifFix.valid || ifVar.valid) pulses++;
        end
        checkOutput("midReset/noValid", 64'(pulses), 64'd0);
        checkOutput("midReset/fix.prodtAfter", ifFix.prodt, 64'h0);
        checkOutput("midReset/var.prodtAfter", ifVar.prodt, 64'h0);

        applyStimulus(32'hFFFF8000, 32'h00012345, 1, 1'b0, "afterReset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
